// File: rtl/pc_lut_pkg.sv
// Shared widths, typedefs and entry layout for the branch-target lookup table.
package pc_pkg;

    localparam int TAG_W = 8;
    localparam int PC_W  = 12;
    localparam int DEPTH = 1 << TAG_W;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [PC_W-1:0]  pc_t;

    typedef struct packed {
        logic valid;
        pc_t  target;
    } lut_entry_t;

endpackage

// File: rtl/pc_lut_if.sv
// Lookup and write-port bundle between the fetch/loader side and the LUT.
interface pc_lut_if;
    import pc_pkg::*;

    tag_t tag;
    pc_t  target;
    logic hit;
    logic wr_en;
    tag_t wr_tag;
    pc_t  wr_target;
    logic clr;

    modport master (
        output tag, wr_en, wr_tag, wr_target, clr,
        input  target, hit
    );

    modport slave (
        input  tag, wr_en, wr_tag, wr_target, clr,
        output target, hit
    );

endinterface

// File: rtl/pc_lut_entry.sv
// Single LUT entry: async reset, synchronous clear (over write), write enable.
module lut_entry
    import pc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_wr_en,
    input  pc_t        i_wr_target,
    output lut_entry_t o_entry
);

    lut_entry_t r_entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entry <= '0;
        end else if (i_clr) begin
            r_entry <= '0;
        end else if (i_wr_en) begin
            r_entry <= '{valid: 1'b1, target: i_wr_target};
        end
    end

    assign o_entry = r_entry;

endmodule

// File: rtl/pc_lut.sv
// Branch-target LUT: one-hot write decode into DEPTH entries, combinational read mux.
module pc_lut
    import pc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    pc_lut_if.slave     bus
);

    logic [DEPTH-1:0]       w_wr_sel;
    lut_entry_t [DEPTH-1:0] w_entries;
    lut_entry_t             w_rd_entry;

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        assign w_wr_sel[g] = bus.wr_en && (bus.wr_tag == tag_t'(g));

        lut_entry u_entry (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_clr       (bus.clr),
            .i_wr_en     (w_wr_sel[g]),
            .i_wr_target (bus.wr_target),
            .o_entry     (w_entries[g])
        );
    end

    // No write-to-read bypass: a same-cycle read sees the pre-edge value.
    assign w_rd_entry = w_entries[bus.tag];
    assign bus.target = w_rd_entry.target;
    assign bus.hit    = w_rd_entry.valid;

endmodule

// File: tb/tb_pc_lut.sv
// Directed-vector bench for pc_lut.
module tb_pc_lut;
    import pc_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pc_lut_if bus ();

    pc_lut dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_read(input string name, input int t, input logic [11:0] exp_tgt,
                               input logic exp_hit);
        bus.tag = tag_t'(t);
        #1;
        checks++;
        if (bus.target !== exp_tgt || bus.hit !== exp_hit) begin
            failures++;
            $display("FAIL %s tag=%0d: got target=%h hit=%b, expected target=%h hit=%b",
                     name, t, bus.target, bus.hit, exp_tgt, exp_hit);
        end
    endtask

    task automatic do_write(input int t, input logic [11:0] v);
        @(negedge clk);
        bus.wr_en     = 1'b1;
        bus.wr_tag    = tag_t'(t);
        bus.wr_target = v;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic test_reset();
        expect_read("reset_during", 1, 12'h000, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_read("reset_tag1", 1, 12'b000000000000, 1'b0);
        for (int i = 0; i < DEPTH; i++) expect_read("reset_sweep", i, 12'h000, 1'b0);
    endtask

    task automatic test_basic_write();
        do_write(1, 12'hABC);
        expect_read("write_tag1", 1, 12'hABC, 1'b1);
        expect_read("write_tag2_untouched", 2, 12'h000, 1'b0);
    endtask

    task automatic test_boundary();
        do_write(0, 12'h001);
        do_write(255, 12'hFFF);
        expect_read("bound_tag0", 0, 12'h001, 1'b1);
        expect_read("bound_tag255", 255, 12'hFFF, 1'b1);
        expect_read("bound_tag254", 254, 12'h000, 1'b0);
        expect_read("bound_tag1_kept", 1, 12'hABC, 1'b1);
    endtask

    task automatic test_same_cycle_clr();
        @(negedge clk);
        bus.wr_en     = 1'b1;
        bus.wr_tag    = 8'd5;
        bus.wr_target = 12'h123;
        expect_read("rw_same_cycle_old", 5, 12'h000, 1'b0);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        expect_read("rw_same_cycle_new", 5, 12'h123, 1'b1);
        @(negedge clk);
        bus.clr       = 1'b1;
        bus.wr_en     = 1'b1;
        bus.wr_tag    = 8'd6;
        bus.wr_target = 12'h456;
        @(posedge clk);
        #1;
        bus.clr   = 1'b0;
        bus.wr_en = 1'b0;
        expect_read("clr_tag5", 5, 12'h000, 1'b0);
        expect_read("clr_wins_tag6", 6, 12'h000, 1'b0);
        expect_read("clr_tag255", 255, 12'h000, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 1; i <= 10; i++) do_write(i, 12'h010 + 12'(i));
        expect_read("populate_tag4", 4, 12'h014, 1'b1);
        expect_read("populate_tag10", 10, 12'h01A, 1'b1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        expect_read("async_rst_tag4", 4, 12'h000, 1'b0);
        expect_read("async_rst_tag10", 10, 12'h000, 1'b0);
        #1;
        rst_n = 1'b1;
        do_write(3, 12'h777);
        expect_read("post_rst_tag3", 3, 12'h777, 1'b1);
        expect_read("post_rst_tag1", 1, 12'h000, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_write(7, 12'h100);
        do_write(7, 12'h200);
        expect_read("b2b_same_tag7", 7, 12'h200, 1'b1);
        do_write(8, 12'h0AA);
        do_write(9, 12'h0BB);
        expect_read("b2b_diff_tag8", 8, 12'h0AA, 1'b1);
        expect_read("b2b_diff_tag9", 9, 12'h0BB, 1'b1);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.tag       = '0;
        bus.wr_en     = 1'b0;
        bus.wr_tag    = '0;
        bus.wr_target = '0;
        bus.clr       = 1'b0;
        #2;
        test_reset();
        test_basic_write();
        test_boundary();
        test_same_cycle_clr();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
